// File: rtl/spi_slave_cmd_ctrl.sv
// Command/control FSM behind an SPI slave shift stage: decodes the command word,
// drives receive/transmit length reloads, and issues memory and config-register strobes.
`timescale 1ns/1ps

module spi_slave_cmd_ctrl (
   input  logic        sclk,
   input  logic        cs,
   input  logic        en_quad,
   input  logic [7:0]  dummy_cycles,
   input  logic [31:0] rx_data,
   input  logic        rx_data_valid,
   output logic [7:0]  rx_counter,
   output logic        rx_counter_upd,
   output logic [7:0]  tx_counter,
   output logic        tx_counter_upd,
   output logic        tx_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        wr_valid,
   output logic [31:0] rd_addr,
   output logic        rd_req,
   output logic [1:0]  reg_addr,
   output logic [7:0]  reg_data,
   output logic        reg_wr
);

   typedef enum logic [2:0] {
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_REGWR,
      ST_DUMMY,
      ST_RDATA,
      ST_IGNORE
   } state_e;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h0B;
   localparam logic [7:0] CMD_REG0  = 8'h01;
   localparam logic [7:0] CMD_REG1  = 8'h11;
   localparam logic [7:0] CMD_REG2  = 8'h21;

   state_e      state_q, state_d;
   logic        is_read_q, is_read_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        wr_valid_q, wr_valid_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic        rd_req_q, rd_req_d;
   logic [1:0]  reg_addr_q, reg_addr_d;
   logic [7:0]  reg_data_q, reg_data_d;
   logic        reg_wr_q, reg_wr_d;

   logic [7:0]  cmd;
   logic [7:0]  word_len;
   logic [7:0]  byte_len;

   assign cmd      = rx_data[7:0];
   assign word_len = en_quad ? 8'd7 : 8'd31;
   assign byte_len = en_quad ? 8'd1 : 8'd7;

   // ---------------------------------------------------------------- state register
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge sclk or posedge cs) begin
      if (cs) begin
         state_q <= ST_CMD;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      if (rx_data_valid) begin
         unique case (state_q)
            ST_CMD: begin
               unique case (cmd)
                  CMD_WRITE, CMD_READ:          state_d = ST_ADDR;
                  CMD_REG0, CMD_REG1, CMD_REG2: state_d = ST_REGWR;
                  default:                      state_d = ST_IGNORE;
               endcase
            end
            ST_ADDR: begin
               if (!is_read_q) begin
                  state_d = ST_WDATA;
               end else if (dummy_cycles != 8'd0) begin
                  state_d = ST_DUMMY;
               end else begin
                  state_d = ST_RDATA;
               end
            end
            ST_REGWR:  state_d = ST_IGNORE;
            ST_DUMMY:  state_d = ST_RDATA;
            ST_WDATA:  state_d = ST_WDATA;
            ST_RDATA:  state_d = ST_RDATA;
            ST_IGNORE: state_d = ST_IGNORE;
            default:   state_d = ST_IGNORE;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   // Counter reloads are combinational so the shift stage loads them on the same
   // edge that completes the current word.
   always_comb begin
      rx_counter     = 8'd0;
      rx_counter_upd = 1'b0;
      tx_counter     = 8'd0;
      tx_counter_upd = 1'b0;
      is_read_d      = is_read_q;
      addr_d         = addr_q;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      wr_valid_d     = 1'b0;
      rd_addr_d      = rd_addr_q;
      rd_req_d       = 1'b0;
      reg_addr_d     = reg_addr_q;
      reg_data_d     = reg_data_q;
      reg_wr_d       = 1'b0;

      if (rx_data_valid) begin
         unique case (state_q)
            ST_CMD: begin
               unique case (cmd)
                  CMD_WRITE, CMD_READ: begin
                     is_read_d      = (cmd == CMD_READ);
                     rx_counter     = word_len;
                     rx_counter_upd = 1'b1;
                  end
                  CMD_REG0, CMD_REG1, CMD_REG2: begin
                     reg_addr_d     = cmd[5:4];
                     rx_counter     = byte_len;
                     rx_counter_upd = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_ADDR: begin
               if (!is_read_q) begin
                  addr_d         = rx_data;
                  rx_counter     = word_len;
                  rx_counter_upd = 1'b1;
               end else begin
                  // First read goes out at the received address; the register
                  // already points at the following word.
                  rd_req_d  = 1'b1;
                  rd_addr_d = rx_data;
                  addr_d    = rx_data + 32'd4;
                  if (dummy_cycles != 8'd0) begin
                     rx_counter     = dummy_cycles - 8'd1;
                     rx_counter_upd = 1'b1;
                  end else begin
                     tx_counter     = word_len;
                     tx_counter_upd = 1'b1;
                  end
               end
            end
            ST_WDATA: begin
               wr_valid_d = 1'b1;
               wr_data_d  = rx_data;
               wr_addr_d  = addr_q;
               addr_d     = addr_q + 32'd4;
            end
            ST_REGWR: begin
               reg_wr_d   = 1'b1;
               reg_data_d = rx_data[7:0];
            end
            ST_DUMMY: begin
               tx_counter     = word_len;
               tx_counter_upd = 1'b1;
               rx_counter     = word_len;
               rx_counter_upd = 1'b1;
            end
            ST_RDATA: begin
               rd_req_d  = 1'b1;
               rd_addr_d = addr_q;
               addr_d    = addr_q + 32'd4;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- datapath registers
   // NOTE: every register here is reset by cs; there is no storage array, so a
   // full reset is cheap and keeps a truncated frame from leaking stale values.
   always_ff @(posedge sclk or posedge cs) begin
      if (cs) begin
         is_read_q  <= 1'b0;
         addr_q     <= 32'd0;
         wr_addr_q  <= 32'd0;
         wr_data_q  <= 32'd0;
         wr_valid_q <= 1'b0;
         rd_addr_q  <= 32'd0;
         rd_req_q   <= 1'b0;
         reg_addr_q <= 2'd0;
         reg_data_q <= 8'd0;
         reg_wr_q   <= 1'b0;
      end else begin
         is_read_q  <= is_read_d;
         addr_q     <= addr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_valid_q <= wr_valid_d;
         rd_addr_q  <= rd_addr_d;
         rd_req_q   <= rd_req_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         reg_wr_q   <= reg_wr_d;
      end
   end

   assign tx_en    = (state_q == ST_RDATA);
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign wr_valid = wr_valid_q;
   assign rd_addr  = rd_addr_q;
   assign rd_req   = rd_req_q;
   assign reg_addr = reg_addr_q;
   assign reg_data = reg_data_q;
   assign reg_wr   = reg_wr_q;

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Self-checking bench for spi_slave_cmd_ctrl: frame-level reference model feeds a
// scoreboard queue; a negedge monitor pops and compares whenever any strobe fires.
`timescale 1ns/1ps

module tb_spi_slave_cmd_ctrl;

   logic        sclk = 1'b0;
   logic        cs = 1'b1;
   logic        en_quad = 1'b0;
   logic [7:0]  dummy_cycles = 8'd0;
   logic [31:0] rx_data = 32'd0;
   logic        rx_data_valid = 1'b0;
   logic [7:0]  rx_counter;
   logic        rx_counter_upd;
   logic [7:0]  tx_counter;
   logic        tx_counter_upd;
   logic        tx_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic [31:0] rd_addr;
   logic        rd_req;
   logic [1:0]  reg_addr;
   logic [7:0]  reg_data;
   logic        reg_wr;

   spi_slave_cmd_ctrl dut (
      .sclk           (sclk),
      .cs             (cs),
      .en_quad        (en_quad),
      .dummy_cycles   (dummy_cycles),
      .rx_data        (rx_data),
      .rx_data_valid  (rx_data_valid),
      .rx_counter     (rx_counter),
      .rx_counter_upd (rx_counter_upd),
      .tx_counter     (tx_counter),
      .tx_counter_upd (tx_counter_upd),
      .tx_en          (tx_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_valid       (wr_valid),
      .rd_addr        (rd_addr),
      .rd_req         (rd_req),
      .reg_addr       (reg_addr),
      .reg_data       (reg_data),
      .reg_wr         (reg_wr)
   );

   always #5 sclk = ~sclk;

   // One expected cycle of strobe activity
   typedef struct {
      bit        rx_upd;
      bit [7:0]  rx_cnt;
      bit        tx_upd;
      bit [7:0]  tx_cnt;
      bit        wr_v;
      bit [31:0] wr_a;
      bit [31:0] wr_d;
      bit        rd_r;
      bit [31:0] rd_a;
      bit        reg_w;
      bit [1:0]  reg_a;
      bit [7:0]  reg_d;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;
   bit  exp_tx_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ev_t ev_zero();
      ev_t e;
      e = '{default: 0};
      return e;
   endfunction

   // ---------------------------------------------------------------- monitor
   always @(negedge sclk) begin
      ev_t e;
      check("tx_en", {31'd0, tx_en}, {31'd0, exp_tx_en});
      check("mem_strobe_exclusive", 32'($countones({wr_valid, rd_req, reg_wr}) <= 1), 32'd1);
      if (rx_counter_upd || tx_counter_upd || wr_valid || rd_req || reg_wr) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got {rx,tx,wr,rd,reg}=%b expected none at %0t",
                     {rx_counter_upd, tx_counter_upd, wr_valid, rd_req, reg_wr}, $time);
         end else begin
            e = sb.pop_front();
            check("strobes", {27'd0, rx_counter_upd, tx_counter_upd, wr_valid, rd_req, reg_wr},
                  {27'd0, e.rx_upd, e.tx_upd, e.wr_v, e.rd_r, e.reg_w});
            if (e.rx_upd) check("rx_counter", {24'd0, rx_counter}, {24'd0, e.rx_cnt});
            if (e.tx_upd) check("tx_counter", {24'd0, tx_counter}, {24'd0, e.tx_cnt});
            if (e.wr_v) begin
               check("wr_addr", wr_addr, e.wr_a);
               check("wr_data", wr_data, e.wr_d);
            end
            if (e.rd_r) check("rd_addr", rd_addr, e.rd_a);
            if (e.reg_w) begin
               check("reg_addr", {30'd0, reg_addr}, {30'd0, e.reg_a});
               check("reg_data", {24'd0, reg_data}, {24'd0, e.reg_d});
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus helpers
   // Inputs change 1ns after the rising edge; at least one idle cycle between words
   // keeps each word's same-cycle and next-cycle strobes in separate cycles.
   task automatic send_word(input logic [31:0] d);
      int gap;
      gap = $urandom_range(3, 1);
      repeat (gap) begin
         @(posedge sclk);
         #1;
      end
      rx_data       = d;
      rx_data_valid = 1'b1;
      @(posedge sclk);
      #1;
      rx_data_valid = 1'b0;
      rx_data       = $urandom;
   endtask

   task automatic reset_checks();
      @(negedge sclk);
      check("rst_wr_addr", wr_addr, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_rd_addr", rd_addr, 32'd0);
      check("rst_reg_addr", {30'd0, reg_addr}, 32'd0);
      check("rst_reg_data", {24'd0, reg_data}, 32'd0);
      check("rst_strobes", {27'd0, rx_counter_upd, tx_counter_upd, wr_valid, rd_req, reg_wr}, 32'd0);
   endtask

   task automatic end_frame();
      @(posedge sclk);
      #1;
      cs        = 1'b1;
      exp_tx_en = 1'b0;
      reset_checks();
      @(posedge sclk);
      #1;
      cs = 1'b0;
   endtask

   // cs raised while a word-complete strobe is presented: nothing may come out
   task automatic abort_frame();
      @(posedge sclk);
      #1;
      cs            = 1'b1;
      exp_tx_en     = 1'b0;
      rx_data       = $urandom;
      rx_data_valid = 1'b1;
      reset_checks();
      @(posedge sclk);
      #1;
      rx_data_valid = 1'b0;
      cs            = 1'b0;
   endtask

   // ---------------------------------------------------------------- reference model
   // Expected events for a whole frame, derived from the command table.
   task automatic run_frame(input logic [7:0] cmd, input bit quad, input logic [7:0] dmy,
                            input logic [31:0] addr, input int nwords,
                            input logic [31:0] d0, input logic [31:0] d1, input bit abort);
      logic [7:0]  wlen, blen;
      logic [31:0] d;
      ev_t         e;
      en_quad      = quad;
      dummy_cycles = dmy;
      wlen = quad ? 8'd7 : 8'd31;
      blen = quad ? 8'd1 : 8'd7;

      e = ev_zero();
      case (cmd)
         8'h02, 8'h0B: begin e.rx_upd = 1; e.rx_cnt = wlen; sb.push_back(e); end
         8'h01, 8'h11, 8'h21: begin e.rx_upd = 1; e.rx_cnt = blen; sb.push_back(e); end
         default: ;
      endcase
      d = $urandom;
      d[7:0] = cmd;
      send_word(d);

      case (cmd)
         8'h02: begin
            e = ev_zero();
            e.rx_upd = 1;
            e.rx_cnt = wlen;
            sb.push_back(e);
            send_word(addr);
            for (int i = 0; i < nwords; i++) begin
               d = (i == 0) ? d0 : (i == 1) ? d1 : 32'($urandom);
               e = ev_zero();
               e.wr_v = 1;
               e.wr_a = addr + 32'(4 * i);
               e.wr_d = d;
               sb.push_back(e);
               send_word(d);
            end
         end
         8'h0B: begin
            e = ev_zero();
            if (dmy != 8'd0) begin
               e.rx_upd = 1;
               e.rx_cnt = dmy - 8'd1;
            end else begin
               e.tx_upd = 1;
               e.tx_cnt = wlen;
            end
            sb.push_back(e);
            e = ev_zero();
            e.rd_r = 1;
            e.rd_a = addr;
            sb.push_back(e);
            send_word(addr);
            exp_tx_en = (dmy == 8'd0);
            if (dmy != 8'd0) begin
               e = ev_zero();
               e.tx_upd = 1;
               e.tx_cnt = wlen;
               e.rx_upd = 1;
               e.rx_cnt = wlen;
               sb.push_back(e);
               send_word($urandom);
               exp_tx_en = 1'b1;
            end
            for (int i = 0; i < nwords; i++) begin
               e = ev_zero();
               e.rd_r = 1;
               e.rd_a = addr + 32'(4 * (i + 1));
               sb.push_back(e);
               send_word($urandom);
            end
         end
         8'h01, 8'h11, 8'h21: begin
            e = ev_zero();
            e.reg_w = 1;
            e.reg_a = (cmd == 8'h01) ? 2'd0 : (cmd == 8'h11) ? 2'd1 : 2'd2;
            e.reg_d = d0[7:0];
            sb.push_back(e);
            send_word(d0);
            for (int i = 0; i < nwords; i++) send_word($urandom);
         end
         default: begin
            for (int i = 0; i <= nwords; i++) send_word($urandom);
         end
      endcase

      if (abort) abort_frame();
      else end_frame();
   endtask

   // ---------------------------------------------------------------- main sequence
   initial begin
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [7:0]  cmd_list [6];
      cmd_list[0] = 8'h02;
      cmd_list[1] = 8'h0B;
      cmd_list[2] = 8'h01;
      cmd_list[3] = 8'h11;
      cmd_list[4] = 8'h21;
      cmd_list[5] = 8'h7F;

      repeat (2) @(posedge sclk);
      #1;
      reset_checks();
      check("rst_tx_en", {31'd0, tx_en}, 32'd0);
      @(posedge sclk);
      #1;
      cs = 1'b0;

      // Directed scenarios
      run_frame(8'h02, 1'b0, 8'd0, 32'h0000_1000, 2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      run_frame(8'h0B, 1'b1, 8'd4, 32'h0000_0020, 2, 32'd0, 32'd0, 1'b0);
      run_frame(8'h0B, 1'b0, 8'd0, 32'h0000_8000, 2, 32'd0, 32'd0, 1'b0);
      run_frame(8'h11, 1'b0, 8'd0, 32'd0, 3, 32'h0000_0005, 32'd0, 1'b0);
      run_frame(8'h7F, 1'b0, 8'd3, 32'd0, 4, 32'd0, 32'd0, 1'b0);
      run_frame(8'h02, 1'b1, 8'd0, 32'hFFFF_FFFC, 2, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0);
      run_frame(8'h02, 1'b0, 8'd0, 32'h0000_0400, 1, 32'hCAFE_F00D, 32'd0, 1'b1);
      run_frame(8'h21, 1'b1, 8'd0, 32'd0, 1, 32'h0000_00C3, 32'd0, 1'b0);
      run_frame(8'h01, 1'b0, 8'd0, 32'd0, 0, 32'h0000_0099, 32'd0, 1'b0);

      // Randomized frames
      for (int n = 0; n < 40; n++) begin
         cmd  = ($urandom_range(5, 0) == 0) ? 8'($urandom) : cmd_list[$urandom_range(5, 0)];
         addr = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : 32'($urandom);
         run_frame(cmd, 1'($urandom_range(1, 0)), 8'($urandom_range(5, 0)), addr,
                   $urandom_range(4, 0), $urandom, $urandom, ($urandom_range(7, 0) == 0));
      end

      repeat (4) @(posedge sclk);
      check("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/spi_slave_cmd_ctrl.md
SPI_SLAVE_CMD_CTRL -- requirements
Module: spi_slave_cmd_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and one reset. Reset is asynchronous and active-high.
REQ-003 Port list (name, direction, width, meaning) SHALL be:
- sclk  in  1  SPI clock; all state is updated on the rising edge.
- cs  in  1  chip select, used as the asynchronous active-high reset.
- en_quad  in  1  1 = quad mode (4 bits/clk), 0 = single mode (1 bit/clk); held stable for the whole frame.
- dummy_cycles  in  8  number of read dummy clocks; 0 is allowed.
- rx_data  in  32  shifted word from the receive stage.
- rx_data_valid  in  1  single-cycle word-complete strobe from the receive stage.
- rx_counter  out  8  next receive length in clocks, minus 1.
- rx_counter_upd  out  1  load strobe for rx_counter.
- tx_counter  out  8  transmit length in clocks, minus 1.
- tx_counter_upd  out  1  load strobe for tx_counter.
- tx_en  out  1  transmit phase active.
- wr_addr  out  32  memory write address.
- wr_data  out  32  memory write data.
- wr_valid  out  1  memory write pulse.
- rd_addr  out  32  memory read address.
- rd_req  out  1  memory read-request pulse.
- reg_addr  out  2  configuration register index.
- reg_data  out  8  configuration register write data.
- reg_wr  out  1  configuration register write pulse.

Function
REQ-004 The state machine SHALL have states CMD, ADDR, WDATA, REGWR, DUMMY, RDATA and IGNORE.
REQ-005 The command is rx_data[7:0], taken in CMD when rx_data_valid=1. Decode:
- 0x02 -> ADDR (write)
- 0x0B -> ADDR (read)
- 0x01, 0x11, 0x21 -> REGWR, with reg_addr = 0, 1, 2 respectively
- any other value -> IGNORE
REQ-006 Word length L SHALL be 8'd7 when en_quad=1, else 8'd31. Byte length B SHALL be 8'd1 when en_quad=1, else 8'd7.
REQ-007 rx_counter and rx_counter_upd are combinational. They SHALL be asserted in the same cycle as the rx_data_valid that triggers them, so the receive stage loads them on that edge.
REQ-008 In the CMD->ADDR and CMD->REGWR cycles, the block SHALL assert rx_counter_upd with rx_counter = L (ADDR) or B (REGWR).
REQ-009 CMD->IGNORE SHALL assert no strobe. IGNORE SHALL be left only by reset.
REQ-010 ADDR, write command: on rx_data_valid, register addr = rx_data, go to WDATA, and assert rx_counter_upd with rx_counter = L.
REQ-011 WDATA: on each rx_data_valid, the next cycle SHALL show wr_valid=1 for exactly one cycle, wr_data = rx_data, and wr_addr = the current address. The address then increments by 4, wrapping modulo 2^32. The receive stage re-arms itself; no new rx_counter_upd is needed.
REQ-012 ADDR, read command: on rx_data_valid, the next cycle SHALL show rd_req=1 for one cycle with rd_addr = rx_data. The address register then increments by 4.
REQ-013 On that same read ADDR edge, when dummy_cycles != 0: go to DUMMY, and assert rx_counter_upd with rx_counter = dummy_cycles - 1.
REQ-014 On that same read ADDR edge, when dummy_cycles == 0: go directly to RDATA, and assert tx_counter_upd with tx_counter = L in the same cycle.
REQ-015 DUMMY: on rx_data_valid, go to RDATA and assert tx_counter_upd with tx_counter = L, plus rx_counter_upd with rx_counter = L.
REQ-016 tx_en SHALL be 1 exactly while the state is RDATA.
REQ-017 RDATA: on each rx_data_valid, the next cycle SHALL show rd_req=1 with rd_addr = the current address. The address then increments by 4.
REQ-018 REGWR: on rx_data_valid, the next cycle SHALL show reg_wr=1 for one cycle with reg_data = rx_data[7:0]. The state then goes to IGNORE.
REQ-019 wr_valid, rd_req and reg_wr SHALL never be asserted in the same cycle.
REQ-020 rx_data_valid arriving in IGNORE SHALL be ignored.

Reset
REQ-021 While cs=1, the block SHALL hold: state = CMD; address = 0; wr_addr, wr_data, rd_addr = 0; reg_addr = 0, reg_data = 0; every strobe = 0; tx_en = 0.
REQ-022 Reset mid-frame SHALL abort with no further strobes. A transfer truncated before its rx_data_valid SHALL produce no wr_valid.

Verification
REQ-023 Single-mode write: cmd 0x02, addr 0x1000, words 0xDEADBEEF and 0x12345678 -> rx_counter_upd with 31 after the command; wr_valid at 0x1000/0xDEADBEEF, then at 0x1004/0x12345678.
REQ-024 Quad read with dummy_cycles=4: cmd 0x0B, addr 0x20 -> rd_req at 0x20; rx_counter=3; tx_counter_upd with 7; tx_en=1; rd_req at 0x24 after the first tx word.
REQ-025 Single-mode read with dummy_cycles=0 -> tx_counter_upd with 31 in the address-valid cycle, and DUMMY is never entered.
REQ-026 Register write: cmd 0x11, data 0x05 -> reg_wr=1, reg_addr=1, reg_data=0x05. Further bits produce no strobes.
REQ-027 Unknown command 0x7F -> zero strobes until cs rises.
REQ-028 Write burst starting at addr 0xFFFFFFFC over two words -> second wr_addr = 0x00000000. cs pulsed mid-word -> no wr_valid, and the next frame decodes from CMD.
